spi_reg_bank: RTL and testbench

- Single-clock register bank that sits directly downstream of the SPI slave interface.
- Captures the SPI address/write-data pulses as {addr,data} command pairs in a small command FIFO, then executes them against the modulator control map: enable/mapping, test, frequency word, and I/Q FIR coefficient shadow memories.
- Serves SPI read requests with fixed latency and forwards coefficient writes to the FIR coefficient RAMs.

---
 rtl/spi_reg_bank_if.sv | 25 ++
 rtl/spi_reg_bank.sv | 216 +++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_if.sv
// SPI-side bus of the register bank: write capture pulses, read request/response, FIFO status.
interface spi_reg_bank_if;
    logic       wr_addr_en;
    logic [9:0] wr_addr;
    logic       wr_data_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       cmd_empty;
    logic       cmd_full;

    // SPI slave side drives requests and observes responses
    modport master (
        output wr_addr_en, wr_addr, wr_data_en, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, cmd_empty, cmd_full
    );

    // Register bank side
    modport slave (
        input  wr_addr_en, wr_addr, wr_data_en, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, cmd_empty, cmd_full
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Modulator control register bank: captures SPI {addr,data} pairs into a command
// FIFO, executes them against the control map and coefficient shadows, and serves
// fixed-latency reads.
module spi_reg_bank #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned NUM_TAPS  = 71
) (
    input  logic          clk,
    input  logic          rst,
    spi_reg_bank_if.slave bus,
    output logic          mod_enable,
    output logic          mapping,
    output logic [7:0]    test_reg,
    output logic [7:0]    freq_word,
    output logic          coeff_we,
    output logic          coeff_q_sel,
    output logic [6:0]    coeff_idx,
    output logic [7:0]    coeff_wdata,
    output logic [8:0]    samp_rd_addr,
    input  logic [7:0]    samp_rd_data,
    output logic [2:0]    err_flags,
    input  logic          err_clr
);

    localparam int unsigned AW        = 10;
    localparam int unsigned DW        = 8;
    localparam int unsigned PTR_W     = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned IDX_W     = PTR_W - 1;
    localparam int unsigned I_BASE    = 128;
    localparam int unsigned Q_BASE    = 256;
    localparam int unsigned SAMP_BASE = 512;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef enum logic {IDLE, EXEC} state_t;

    cmd_t             fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt_c, rd_ptr_nxt_c;
    logic             pend_valid;
    logic [AW-1:0]    pend_addr;
    logic             push_req_c, push_ok_c, pop_c, ovf_c, orphan_c;

    state_t           state;
    cmd_t             cmd_reg;
    logic             cmd_hit_i_c, cmd_hit_q_c, cmd_hit_ctrl_c, exec_bad_c;
    logic [6:0]       cmd_idx_c;

    logic [DW-1:0]    shadow_i [NUM_TAPS];
    logic [DW-1:0]    shadow_q [NUM_TAPS];

    logic             rd_hit_i_c, rd_hit_q_c, rd_samp_c;
    logic [6:0]       rd_i_idx_c, rd_q_idx_c;
    logic [DW-1:0]    rd_word_c;
    logic             rd_valid_p1, rd_valid_p2, rd_samp_p1, rd_samp_p2;
    logic [DW-1:0]    rd_word_p1, rd_word_p2;

    // Push/pop qualification; a full FIFO still accepts a push when a pop frees a slot
    always_comb begin
        push_req_c   = bus.wr_data_en & pend_valid;
        orphan_c     = bus.wr_data_en & ~pend_valid;
        pop_c        = (state == IDLE) && !bus.cmd_empty;
        push_ok_c    = push_req_c && (!bus.cmd_full || pop_c);
        ovf_c        = push_req_c && bus.cmd_full && !pop_c;
        wr_ptr_nxt_c = wr_ptr + PTR_W'(push_ok_c);
        rd_ptr_nxt_c = rd_ptr + PTR_W'(pop_c);
    end

    // Pending address, FIFO pointers, registered status flags and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid    <= 1'b0;
            pend_addr     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.cmd_empty <= 1'b1;
            bus.cmd_full  <= 1'b0;
            err_flags     <= '0;
        end else begin
            // Data pairs with the previously pending address before a same-cycle address lands
            if (bus.wr_addr_en) begin
                pend_valid <= 1'b1;
                pend_addr  <= bus.wr_addr;
            end else if (bus.wr_data_en) begin
                pend_valid <= 1'b0;
            end
            wr_ptr        <= wr_ptr_nxt_c;
            rd_ptr        <= rd_ptr_nxt_c;
            bus.cmd_empty <= (wr_ptr_nxt_c == rd_ptr_nxt_c);
            bus.cmd_full  <= (wr_ptr_nxt_c[PTR_W-1] != rd_ptr_nxt_c[PTR_W-1]) &&
                             (wr_ptr_nxt_c[IDX_W-1:0] == rd_ptr_nxt_c[IDX_W-1:0]);
            err_flags     <= (err_flags & ~{3{err_clr}}) | {exec_bad_c, orphan_c, ovf_c};
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= '{addr: pend_addr, data: bus.wr_data};
        end
    end

    // Address decode of the command under execution
    always_comb begin
        cmd_hit_ctrl_c = (cmd_reg.addr <= AW'(2));
        cmd_hit_i_c    = (cmd_reg.addr >= AW'(I_BASE)) && (cmd_reg.addr < AW'(I_BASE + NUM_TAPS));
        cmd_hit_q_c    = (cmd_reg.addr >= AW'(Q_BASE)) && (cmd_reg.addr < AW'(Q_BASE + NUM_TAPS));
        cmd_idx_c      = cmd_hit_q_c ? 7'(cmd_reg.addr - AW'(Q_BASE))
                                     : 7'(cmd_reg.addr - AW'(I_BASE));
        exec_bad_c     = (state == EXEC) && !(cmd_hit_ctrl_c || cmd_hit_i_c || cmd_hit_q_c);
    end

    // Execute FSM: pop in IDLE, commit at the edge that ends EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_reg     <= '0;
            mod_enable  <= 1'b0;
            mapping     <= 1'b0;
            test_reg    <= '0;
            freq_word   <= '0;
            coeff_we    <= 1'b0;
            coeff_q_sel <= 1'b0;
            coeff_idx   <= '0;
            coeff_wdata <= '0;
        end else begin
            coeff_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        cmd_reg <= fifo_mem[rd_ptr[IDX_W-1:0]];
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    state <= IDLE;
                    if (cmd_reg.addr == AW'(0)) begin
                        mod_enable <= cmd_reg.data[0];
                        mapping    <= cmd_reg.data[1];
                    end else if (cmd_reg.addr == AW'(1)) begin
                        test_reg <= cmd_reg.data;
                    end else if (cmd_reg.addr == AW'(2)) begin
                        freq_word <= cmd_reg.data;
                    end else if (cmd_hit_i_c || cmd_hit_q_c) begin
                        coeff_we    <= 1'b1;
                        coeff_q_sel <= cmd_hit_q_c;
                        coeff_idx   <= cmd_idx_c;
                        coeff_wdata <= cmd_reg.data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient shadows mirror the FIR RAMs for readback; contents undefined until written
    always_ff @(posedge clk) begin
        if (state == EXEC && cmd_hit_i_c) begin
            shadow_i[cmd_idx_c] <= cmd_reg.data;
        end
        if (state == EXEC && cmd_hit_q_c) begin
            shadow_q[cmd_idx_c] <= cmd_reg.data;
        end
    end

    // Read mux, evaluated on the request cycle so a colliding commit returns the old value
    always_comb begin
        rd_i_idx_c = 7'(bus.rd_addr - AW'(I_BASE));
        rd_q_idx_c = 7'(bus.rd_addr - AW'(Q_BASE));
        rd_hit_i_c = (bus.rd_addr >= AW'(I_BASE)) && (bus.rd_addr < AW'(I_BASE + NUM_TAPS));
        rd_hit_q_c = (bus.rd_addr >= AW'(Q_BASE)) && (bus.rd_addr < AW'(Q_BASE + NUM_TAPS));
        rd_samp_c  = (bus.rd_addr >= AW'(SAMP_BASE));
        rd_word_c  = '0;
        if (bus.rd_addr == AW'(0)) begin
            rd_word_c = {6'b0, mapping, mod_enable};
        end else if (bus.rd_addr == AW'(1)) begin
            rd_word_c = test_reg;
        end else if (bus.rd_addr == AW'(2)) begin
            rd_word_c = freq_word;
        end else if (rd_hit_i_c) begin
            rd_word_c = shadow_i[rd_i_idx_c];
        end else if (rd_hit_q_c) begin
            rd_word_c = shadow_q[rd_q_idx_c];
        end
    end

    // Two-stage read pipeline; sample buffer data joins at the second stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_p1  <= 1'b0;
            rd_valid_p2  <= 1'b0;
            rd_samp_p1   <= 1'b0;
            rd_samp_p2   <= 1'b0;
            rd_word_p1   <= '0;
            rd_word_p2   <= '0;
            samp_rd_addr <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            rd_valid_p1  <= bus.rd_en;
            rd_samp_p1   <= rd_samp_c;
            rd_word_p1   <= rd_word_c;
            samp_rd_addr <= bus.rd_addr[8:0];
            rd_valid_p2  <= rd_valid_p1;
            rd_samp_p2   <= rd_samp_p1;
            rd_word_p2   <= rd_word_p1;
            bus.rd_valid <= rd_valid_p2;
            if (rd_valid_p2) begin
                bus.rd_data <= rd_samp_p2 ? samp_rd_data : rd_word_p2;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: expected reads and coefficient strobes are
// queued at issue time and matched by independent monitors.
module tb_spi_reg_bank;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    typedef struct {
        logic       q;
        logic [6:0] idx;
        logic [7:0] data;
        int         cyc;
    } cf_exp_t;

    logic       clk;
    logic       rst;
    logic       mod_enable, mapping, coeff_we, coeff_q_sel, err_clr;
    logic [7:0] test_reg, freq_word, coeff_wdata, samp_rd_data;
    logic [6:0] coeff_idx;
    logic [8:0] samp_rd_addr;
    logic [2:0] err_flags;

    spi_reg_bank_if bus ();

    spi_reg_bank #(.CMD_DEPTH(4), .NUM_TAPS(71)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mod_enable   (mod_enable),
        .mapping      (mapping),
        .test_reg     (test_reg),
        .freq_word    (freq_word),
        .coeff_we     (coeff_we),
        .coeff_q_sel  (coeff_q_sel),
        .coeff_idx    (coeff_idx),
        .coeff_wdata  (coeff_wdata),
        .samp_rd_addr (samp_rd_addr),
        .samp_rd_data (samp_rd_data),
        .err_flags    (err_flags),
        .err_clr      (err_clr)
    );

    int      n_vec = 0;
    int      n_err = 0;
    int      cyc   = 0;
    rd_exp_t rd_q[$];
    cf_exp_t cf_q[$];
    rd_exp_t mon_rd;
    cf_exp_t mon_cf;
    int      dc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample buffer model: synchronous read, data = addr[7:0] ^ 0x64
    always @(posedge clk) samp_rd_data <= samp_rd_addr[7:0] ^ 8'h64;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Read response monitor
    always @(negedge clk) begin
        if (!rst && bus.rd_valid) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got 0x%0h at cycle %0d, required no response", bus.rd_data, cyc);
            end else begin
                mon_rd = rd_q.pop_front();
                if (bus.rd_data !== mon_rd.data || cyc != mon_rd.cyc) begin
                    n_err++;
                    $display("FAIL rd_data: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                             bus.rd_data, cyc, mon_rd.data, mon_rd.cyc);
                end
            end
        end
    end

    // Coefficient strobe monitor
    always @(negedge clk) begin
        if (!rst && coeff_we) begin
            n_vec++;
            if (cf_q.size() == 0) begin
                n_err++;
                $display("FAIL coeff_unexpected: got q=%0d idx=%0d d=0x%0h, required no strobe",
                         coeff_q_sel, coeff_idx, coeff_wdata);
            end else begin
                mon_cf = cf_q.pop_front();
                if (coeff_q_sel !== mon_cf.q || coeff_idx !== mon_cf.idx || coeff_wdata !== mon_cf.data ||
                    (mon_cf.cyc >= 0 && cyc != mon_cf.cyc)) begin
                    n_err++;
                    $display("FAIL coeff_write: got q=%0d idx=%0d d=0x%0h cyc=%0d, required q=%0d idx=%0d d=0x%0h cyc=%0d",
                             coeff_q_sel, coeff_idx, coeff_wdata, cyc, mon_cf.q, mon_cf.idx, mon_cf.data, mon_cf.cyc);
                end
            end
        end
    end

    // Advance to the next falling edge and retire all one-cycle pulses
    task automatic step();
        @(negedge clk);
        bus.wr_addr_en = 1'b0;
        bus.wr_data_en = 1'b0;
        bus.rd_en      = 1'b0;
        err_clr        = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic write_pair(input int a, input logic [7:0] d, output int data_cyc);
        step();
        bus.wr_addr_en = 1'b1;
        bus.wr_addr    = 10'(a);
        step();
        bus.wr_data_en = 1'b1;
        bus.wr_data    = d;
        data_cyc       = cyc;
        if (a >= 128 && a < 199) cf_q.push_back('{1'b0, 7'(a - 128), d, cyc + 3});
        if (a >= 256 && a < 327) cf_q.push_back('{1'b1, 7'(a - 256), d, cyc + 3});
        step();
    endtask

    task automatic rd(input int a, input logic [7:0] exp);
        step();
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'(a);
        rd_q.push_back('{exp, cyc + 3});
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        bus.wr_addr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_data_en = 1'b0; bus.wr_data = '0;
        bus.rd_en = 1'b0;      bus.rd_addr = '0;
        step(); step();
        check("reset_ctrl", {mod_enable, mapping, test_reg, freq_word}, 18'h0);
        check("reset_coeff", {coeff_we, coeff_q_sel, coeff_idx, coeff_wdata}, 17'h0);
        check("reset_status", {bus.cmd_empty, bus.cmd_full, bus.rd_valid, bus.rd_data, err_flags}, 14'h2000);
        step();
        rst = 1'b0;

        // Control register write latency and readback
        write_pair(0, 8'h03, dc);
        wait_cyc(dc + 2);
        check("latency_before_commit", {mod_enable, mapping}, 2'b00);
        wait_cyc(dc + 3);
        check("ctrl_commit", {mod_enable, mapping}, 2'b11);
        rd(0, 8'h03);
        step();

        // Coefficient writes, including range boundaries
        write_pair(130, 8'h5A, dc);
        write_pair(258, 8'hA5, dc);
        write_pair(1, 8'h77, dc);
        write_pair(2, 8'h9C, dc);
        write_pair(198, 8'h11, dc);
        write_pair(326, 8'h22, dc);
        write_pair(128, 8'h33, dc);
        write_pair(256, 8'h44, dc);
        wait_cyc(dc + 4);
        check("regs_after_writes", {test_reg, freq_word}, 16'h779C);
        check("no_err_valid_writes", err_flags, 3'b000);
        rd(130, 8'h5A); rd(258, 8'hA5);
        rd(198, 8'h11); rd(326, 8'h22); rd(128, 8'h33); rd(256, 8'h44);
        step();

        // Pipelined reads across registers, sample buffer and unmapped holes
        rd(1, 8'h77); rd(2, 8'h9C); rd(600, 8'h3C);
        rd(512, 8'h64); rd(1023, 8'h9B); rd(511, 8'h00);
        rd(3, 8'h00); rd(199, 8'h00); rd(327, 8'h00);
        step();
        wait_cyc(cyc + 4);

        // Ten pairs pushed back to back: the ninth meets a full FIFO with no pop and is dropped
        step();
        bus.wr_addr_en = 1'b1;
        bus.wr_addr    = 10'(128);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 8) check("fifo_full", bus.cmd_full, 1'b1);
            bus.wr_data_en = 1'b1;
            bus.wr_data    = 8'(8'h10 + k - 1);
            if (k != 9) cf_q.push_back('{1'b0, 7'(k - 1), 8'(8'h10 + k - 1), -1});
            if (k < 10) begin
                bus.wr_addr_en = 1'b1;
                bus.wr_addr    = 10'(128 + k);
            end
        end
        step();
        wait_cyc(cyc + 14);
        check("overflow_err", err_flags, 3'b001);
        check("fifo_drained", {bus.cmd_empty, bus.cmd_full}, 2'b10);
        rd(137, 8'h19); rd(135, 8'h17);
        step();

        // Orphan data; err_clr with a same-cycle new error keeps that error
        bus.wr_data_en = 1'b1;
        bus.wr_data    = 8'h55;
        err_clr        = 1'b1;
        step();
        check("clr_with_orphan", err_flags, 3'b010);
        wait_cyc(cyc + 4);
        check("orphan_no_commit", {test_reg, freq_word, mod_enable, mapping}, 18'h1DE73);
        err_clr = 1'b1;
        step();
        check("err_clear", err_flags, 3'b000);

        // Read-only and unmapped writes
        write_pair(700, 8'hFF, dc);
        wait_cyc(dc + 4);
        check("readonly_err", err_flags, 3'b100);
        check("readonly_no_change", {test_reg, freq_word, mod_enable, mapping}, 18'h1DE73);
        err_clr = 1'b1;
        step();
        write_pair(199, 8'h12, dc);
        write_pair(3, 8'h12, dc);
        wait_cyc(dc + 4);
        check("unmapped_err", err_flags, 3'b100);
        err_clr = 1'b1;
        step();
        check("err_clear2", err_flags, 3'b000);

        // Read sampled on the commit edge returns the old value
        write_pair(1, 8'hC1, dc);
        rd(1, 8'h77);
        rd(1, 8'hC1);
        step();
        wait_cyc(cyc + 4);

        // Reset while a coefficient strobe is high and a command is still queued
        step();
        bus.wr_addr_en = 1'b1; bus.wr_addr = 10'(140);
        step();
        bus.wr_data_en = 1'b1; bus.wr_data = 8'h6E;
        bus.wr_addr_en = 1'b1; bus.wr_addr = 10'(2);
        cf_q.push_back('{1'b0, 7'd12, 8'h6E, cyc + 3});
        step();
        bus.wr_data_en = 1'b1; bus.wr_data = 8'hE1;
        step();
        step();
        check("queued_before_reset", {coeff_we, bus.cmd_empty}, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("reset_coeff_we", coeff_we, 1'b0);
        check("reset_mid_empty", {bus.cmd_empty, bus.cmd_full}, 2'b10);
        check("reset_mid_ctrl", {mod_enable, mapping, test_reg, freq_word, err_flags}, 21'h0);
        step();
        rst = 1'b0;
        wait_cyc(cyc + 6);
        check("flushed_cmd_dropped", {freq_word, bus.cmd_empty}, 9'h001);

        // Normal operation after reset
        write_pair(0, 8'h02, dc);
        wait_cyc(dc + 3);
        check("post_reset_ctrl", {mod_enable, mapping}, 2'b01);
        write_pair(257, 8'h3D, dc);
        wait_cyc(dc + 3);
        rd(0, 8'h02); rd(1, 8'h00); rd(257, 8'h3D);
        step();

        for (int i = 0; i < 30 && (rd_q.size() != 0 || cf_q.size() != 0); i++) step();
        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        check("coeff_queue_drained", 64'(cf_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
